// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, default timing constants and parity helper
// for the FIFO-fed UART transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS_DEF = 8;
    // Zero-extended upper bits do not disturb the XOR, so narrow words can share this.
    function automatic logic parity_f(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read side plus serial line and status of the transmitter.
interface fifo_uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_rd_en;
    logic                 tx;
    logic                 busy;
    logic                 tx_done_tick;
    modport master (
        input  fifo_empty, fifo_rd_data,
        output fifo_rd_en, tx, busy, tx_done_tick
    );
    modport slave (
        output fifo_empty, fifo_rd_data,
        input  fifo_rd_en, tx, busy, tx_done_tick
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops a first-word-fall-through FIFO when idle and sends each word
// as start, LSB-first data, optional parity and stop bits on a registered line.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           arst_n,
    fifo_uart_tx_if.master bus
);
    localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_db
        $error("fifo_uart_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 rd_en;
    logic                 bit_end;
    assign bit_end = baud_q == BIT_END;
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    shift_d = bus.fifo_rd_data;
                    par_d   = parity_f(8'(bus.fifo_rd_data), PARITY_ODD != 0);
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                baud_d  = '0;
                state_d = DATA;
            end
            DATA: if (bit_end) begin
                baud_d  = '0;
                shift_d = shift_q >> 1;
                bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
                state_d = (bit_q != LAST_BIT) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) begin
                baud_d  = '0;
                state_d = STOP;
            end
            STOP: if (baud_q == STOP_END) begin
                baud_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Line level follows the state being entered so tx changes on the same edge as state.
    assign tx_d = (state_d == START)  ? 1'b0 :
                  (state_d == DATA)   ? shift_d[0] :
                  (state_d == PARITY) ? par_d : 1'b1;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= state_d != IDLE;
        end
    end
    assign bus.fifo_rd_en   = rd_en;
    assign bus.tx           = tx_q;
    assign bus.busy         = busy_q;
    assign bus.tx_done_tick = (state_q == STOP) && (baud_q == STOP_END);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: four transmitter configurations (8N1, 8E1, 8O1, 8N2) at 4 clocks/bit,
// each fed by a small bench FIFO; frames are compared cycle by cycle to hand-built bit words.
module tb_fifo_uart_tx;
    logic clk, arst_n;
    int   checks = 0, fails = 0, cyc = 0;
    fifo_uart_tx_if #(.DATA_BITS(8)) if_a ();
    fifo_uart_tx_if #(.DATA_BITS(8)) if_e ();
    fifo_uart_tx_if #(.DATA_BITS(8)) if_o ();
    fifo_uart_tx_if #(.DATA_BITS(8)) if_s ();
    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
        dut_a (.clk(clk), .arst_n(arst_n), .bus(if_a.master));
    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
        dut_e (.clk(clk), .arst_n(arst_n), .bus(if_e.master));
    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
        dut_o (.clk(clk), .arst_n(arst_n), .bus(if_o.master));
    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0))
        dut_s (.clk(clk), .arst_n(arst_n), .bus(if_s.master));
    logic [7:0] fmem [4][16];
    logic [3:0] head [4] = '{default: '0};
    logic [3:0] tail [4] = '{default: '0};
    logic [3:0] tx_v, busy_v, rd_en_v, done_v;
    assign tx_v    = {if_s.tx, if_o.tx, if_e.tx, if_a.tx};
    assign busy_v  = {if_s.busy, if_o.busy, if_e.busy, if_a.busy};
    assign rd_en_v = {if_s.fifo_rd_en, if_o.fifo_rd_en, if_e.fifo_rd_en, if_a.fifo_rd_en};
    assign done_v  = {if_s.tx_done_tick, if_o.tx_done_tick, if_e.tx_done_tick, if_a.tx_done_tick};
    assign if_a.fifo_empty = head[0] == tail[0];
    assign if_e.fifo_empty = head[1] == tail[1];
    assign if_o.fifo_empty = head[2] == tail[2];
    assign if_s.fifo_empty = head[3] == tail[3];
    assign if_a.fifo_rd_data = fmem[0][head[0]];
    assign if_e.fifo_rd_data = fmem[1][head[1]];
    assign if_o.fifo_rd_data = fmem[2][head[2]];
    assign if_s.fifo_rd_data = fmem[3][head[3]];
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) if (rd_en_v[k]) head[k] <= head[k] + 4'd1;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask
    task automatic push(input int k, input logic [7:0] d);
        fmem[k][tail[k]] = d;
        tail[k] = tail[k] + 4'd1;
    endtask
    // w holds the expected level of serial bit i in w[i]; every cycle of the frame is compared.
    task automatic run_frame(input int k, input logic [15:0] w, input int len, input string nm,
                             input int push_at, input logic [7:0] push_d, output int start);
        int pops = 0, bad = 0, done_at = -1, n = 0;
        start = -1;
        #1;
        while (tx_v[k] && n < 100) begin
            pops += int'(rd_en_v[k]);
            step();
            n++;
        end
        if (tx_v[k]) begin
            chk({nm, "_start"}, 0, 1);
            return;
        end
        start = cyc;
        for (int c = 1; c <= len; c++) begin
            if (tx_v[k] !== w[(c-1)/4] || busy_v[k] !== 1'b1) bad++;
            if (done_v[k]) done_at = (done_at < 0) ? c : -2;
            pops += int'(rd_en_v[k]);
            if (c == push_at) push(k, push_d);
            step();
        end
        chk({nm, "_pops"}, pops, 1);
        chk({nm, "_tx_busy_bad_cycles"}, bad, 0);
        chk({nm, "_done_cycle"}, done_at, len);
    endtask
    typedef struct {
        int         k;
        logic [7:0] d;
        logic [15:0] w;
        int         len;
        int         gap;
    } vec_t;
    vec_t vecs [10];
    initial begin
        int st, st2, prev, bad, n;
        vecs = '{
            '{0, 8'hA5, 16'h034A, 40, 0},
            '{0, 8'h00, 16'h0200, 40, 0},
            '{0, 8'hFF, 16'h03FE, 40, 41},
            '{0, 8'h55, 16'h02AA, 40, 41},
            '{1, 8'h07, 16'h060E, 44, 0},
            '{1, 8'h03, 16'h0406, 44, 0},
            '{2, 8'h07, 16'h040E, 44, 0},
            '{2, 8'h03, 16'h0606, 44, 0},
            '{3, 8'h3C, 16'h0678, 44, 0},
            '{3, 8'hC3, 16'h0786, 44, 45}
        };
        arst_n = 1'b0;
        step();
        step();
        chk("rst_tx", int'(tx_v), 15);
        chk("rst_busy", int'(busy_v), 0);
        chk("rst_rd_en", int'(rd_en_v), 0);
        chk("rst_done", int'(done_v), 0);
        arst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_v !== 4'hF || busy_v !== 4'h0 || rd_en_v !== 4'h0 || done_v !== 4'h0) bad++;
            step();
        end
        chk("idle_empty_bad_cycles", bad, 0);
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].gap == 0) begin
                push(vecs[i].k, vecs[i].d);
                for (int j = i + 1; j < 10 && vecs[j].gap != 0; j++) push(vecs[j].k, vecs[j].d);
            end
            run_frame(vecs[i].k, vecs[i].w, vecs[i].len, $sformatf("vec%0d", i), 0, 8'h00, st);
            if (vecs[i].gap != 0) chk($sformatf("vec%0d_gap", i), st - prev, vecs[i].gap);
            prev = st;
        end
        repeat (5) step();
        push(0, 8'hA5);
        n = 0;
        while (tx_v[0] && n < 100) begin
            step();
            n++;
        end
        chk("abort_started", int'(tx_v[0]), 0);
        repeat (17) step();
        chk("abort_pre_tx_bit3", int'(tx_v[0]), 0);
        chk("abort_pre_busy", int'(busy_v[0]), 1);
        arst_n = 1'b0;
        #1;
        chk("abort_async_tx", int'(tx_v[0]), 1);
        chk("abort_async_busy", int'(busy_v[0]), 0);
        step();
        step();
        arst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
            step();
        end
        chk("post_abort_quiet_bad_cycles", bad, 0);
        push(0, 8'h81);
        run_frame(0, 16'h0302, 40, "midpush", 10, 8'h18, st);
        run_frame(0, 16'h0230, 40, "after_midpush", 0, 8'h00, st2);
        chk("after_midpush_gap", st2 - st, 41);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
UART transmitter that drains the status FIFO on its read side. It sits directly downstream of the FIFO controller and register file. When the FIFO is non-empty and the transmitter is idle, it pops one word and serialises it as an asynchronous frame: start bit, data LSB first, optional parity, then stop bit(s). FIFO read data is first-word-fall-through: the word at the read address is valid whenever fifo_empty is low.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2, checked at elaboration
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty status
fifo_rd_data  input  DATA_BITS  FIFO head word, valid while fifo_empty=0
fifo_rd_en  output  1  pop strobe to FIFO read interface
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress (any state except IDLE)
tx_done_tick  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Clock and reset: single clock clk; reset arst_n is asynchronous and active-low. In reset: tx=1, fifo_rd_en=0, busy=0, tx_done_tick=0, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP. Transitions are IDLE->START->DATA->(PARITY if PARITY_EN)->STOP->IDLE.
- IDLE:
  - fifo_rd_en = (state==IDLE) && !fifo_empty. This is combinational and lasts exactly one cycle per frame.
  - In the same cycle: shift register <= fifo_rd_data, parity register computed from fifo_rd_data, state <= START.
- fifo_rd_en is never asserted while fifo_empty=1 or while state != IDLE.
- Latency: fifo_rd_en high in cycle N -> tx low from cycle N+1.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - Shift register LSB driven on tx.
  - Each bit lasts CLKS_PER_BIT cycles. Shift right at the end of each bit.
  - The bit counter counts 0..DATA_BITS-1.
- PARITY: parity bit on tx for CLKS_PER_BIT cycles.
  - Even parity = XOR of data bits.
  - Odd parity = XNOR of data bits.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done_tick=1 on the final cycle, then state <= IDLE.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: one IDLE cycle (tx=1) between frames, so the frame period is frame length + 1.
- Counter widths:
  - Baud counter: $clog2(STOP_BITS*CLKS_PER_BIT) bits, reset to 0 at each bit or state boundary.
  - Bit counter: $clog2(DATA_BITS) bits (minimum 1).
  - No wrap beyond the terminal count.
- fifo_empty changes mid-frame: ignored until the block returns to IDLE.
- Reset mid-frame: tx goes high immediately (asynchronous) and the frame is aborted. The word already popped is lost, by design. After release, the block waits in IDLE for a non-empty FIFO.
- busy is registered from state and equals (state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparam defaults CLKS_PER_BIT_DEF=868 and DATA_BITS_DEF=8
  - function parity_f(data, odd)
- No sub-module: the baud and bit counters are inline in fifo_uart_tx. The baud counter is simple enough that splitting it adds only port overhead.

Test Plan:
1. Reset, CLKS_PER_BIT=4, fifo_empty=1 -> tx=1, busy=0, fifo_rd_en=0 and tx_done_tick=0 for 100 cycles.
2. One word 0xA5 (8N1, CLKS_PER_BIT=4) -> fifo_rd_en high exactly 1 cycle. tx pattern is 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles (40 cycles total). tx_done_tick on cycle 40 after the first tx-low cycle.
3. Three words 0x00, 0xFF, 0x55 queued -> 3 single-cycle pops. Frame starts (tx falling edges) are 41 cycles apart. Decoded bytes match in order.
4. PARITY_EN=1, PARITY_ODD=0, word 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame length is 44 cycles at CLKS_PER_BIT=4.
5. STOP_BITS=2, word 0x3C -> stop high for 8 cycles. tx_done_tick fires on the 8th stop cycle. The next frame starts 1 cycle later.
6. Assert arst_n low during DATA bit 3 -> tx=1 and busy=0 without waiting for a clock edge. After release with fifo_empty=1, no pop and no tx activity. With fifo_empty toggled mid-frame, fifo_rd_en stays 0 until IDLE.
